id_ex_stage: RTL and testbench

ID/EX pipeline stage that sits directly upstream of the RV32I ALU. It accepts decoded instructions from decode over a valid/ready handshake and buffers them in a main register plus a one-entry skid register. Each cycle it resolves operand forwarding from EX/MEM and MEM/WB and detects load-use hazards. It drives alu_op, in0 and in1 to the ALU, and carries rd_addr and rd_wen forward to EX/MEM.

---
 rtl/id_ex_stage.sv | 160 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: main + skid buffering of decoded instructions, operand
// forwarding from EX/MEM and MEM/WB, and load-use stall in front of the ALU.
module id_ex_stage #(
    parameter int unsigned N_BITS     = 32,
    parameter int unsigned N_REG_BITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    // decode side
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_alu_op,
    input  logic [N_REG_BITS-1:0] in_rs1_addr,
    input  logic [N_REG_BITS-1:0] in_rs2_addr,
    input  logic [N_BITS-1:0]     in_rs1_data,
    input  logic [N_BITS-1:0]     in_rs2_data,
    input  logic [N_BITS-1:0]     in_imm,
    input  logic                  in_use_imm,
    input  logic [N_REG_BITS-1:0] in_rd_addr,
    input  logic                  in_rd_wen,
    input  logic                  flush,
    // result buses
    input  logic                  fwd_ex_wen,
    input  logic [N_REG_BITS-1:0] fwd_ex_rd,
    input  logic [N_BITS-1:0]     fwd_ex_data,
    input  logic                  fwd_ex_is_load,
    input  logic                  fwd_wb_wen,
    input  logic [N_REG_BITS-1:0] fwd_wb_rd,
    input  logic [N_BITS-1:0]     fwd_wb_data,
    // ALU / EX-MEM side
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            alu_op,
    output logic [N_BITS-1:0]     alu_in0,
    output logic [N_BITS-1:0]     alu_in1,
    output logic [N_REG_BITS-1:0] out_rd_addr,
    output logic                  out_rd_wen
);

    localparam int unsigned OP_BITS = 4;

    typedef struct packed {
        logic [OP_BITS-1:0]    alu_op;
        logic [N_REG_BITS-1:0] rs1_addr;
        logic [N_REG_BITS-1:0] rs2_addr;
        logic [N_BITS-1:0]     rs1_data;
        logic [N_BITS-1:0]     rs2_data;
        logic [N_BITS-1:0]     imm;
        logic                  use_imm;
        logic [N_REG_BITS-1:0] rd_addr;
        logic                  rd_wen;
    } entry_t;

    entry_t main_q, main_n;
    entry_t skid_q, skid_n;
    entry_t in_entry;
    logic   main_valid, main_valid_n;
    logic   skid_valid, skid_valid_n;
    logic   accept;
    logic   fire;
    logic   hazard;
    logic   rs1_nz, rs2_nz;
    logic   rs1_ex_hit, rs2_ex_hit;

    assign in_entry = '{
        alu_op:   in_alu_op,
        rs1_addr: in_rs1_addr,
        rs2_addr: in_rs2_addr,
        rs1_data: in_rs1_data,
        rs2_data: in_rs2_data,
        imm:      in_imm,
        use_imm:  in_use_imm,
        rd_addr:  in_rd_addr,
        rd_wen:   in_rd_wen
    };

    // skid_valid is a flop, so in_ready is a registered signal
    assign in_ready = ~skid_valid;
    assign accept   = in_valid & in_ready;
    assign fire     = out_valid & out_ready;

    // Load-use stall: a load result is not available on the EX/MEM bus yet
    assign rs1_nz     = (main_q.rs1_addr != '0);
    assign rs2_nz     = (main_q.rs2_addr != '0);
    assign rs1_ex_hit = (fwd_ex_rd == main_q.rs1_addr);
    assign rs2_ex_hit = (fwd_ex_rd == main_q.rs2_addr) & ~main_q.use_imm;
    assign hazard     = main_valid & fwd_ex_is_load & fwd_ex_wen & (fwd_ex_rd != '0)
                      & (rs1_ex_hit | rs2_ex_hit);
    assign out_valid  = main_valid & ~hazard;

    assign alu_op      = main_q.alu_op;
    assign out_rd_addr = main_q.rd_addr;
    assign out_rd_wen  = main_q.rd_wen;

    // Operand forwarding: EX/MEM has priority over MEM/WB, x0 never forwarded
    always_comb begin
        alu_in0 = main_q.rs1_data;
        alu_in1 = main_q.rs2_data;
        if (fwd_ex_wen && rs1_nz && (fwd_ex_rd == main_q.rs1_addr)) begin
            alu_in0 = fwd_ex_data;
        end else if (fwd_wb_wen && rs1_nz && (fwd_wb_rd == main_q.rs1_addr)) begin
            alu_in0 = fwd_wb_data;
        end
        if (main_q.use_imm) begin
            alu_in1 = main_q.imm;
        end else if (fwd_ex_wen && rs2_nz && (fwd_ex_rd == main_q.rs2_addr)) begin
            alu_in1 = fwd_ex_data;
        end else if (fwd_wb_wen && rs2_nz && (fwd_wb_rd == main_q.rs2_addr)) begin
            alu_in1 = fwd_wb_data;
        end
    end

    // Main/skid next state; main always holds the older entry
    always_comb begin
        main_n       = main_q;
        skid_n       = skid_q;
        main_valid_n = main_valid;
        skid_valid_n = skid_valid;
        if (flush) begin
            main_valid_n = 1'b0;
            skid_valid_n = 1'b0;
        end else if (!main_valid) begin
            if (accept) begin
                main_n       = in_entry;
                main_valid_n = 1'b1;
            end
        end else if (fire) begin
            if (skid_valid) begin
                main_n = skid_q;
                if (accept) begin
                    skid_n = in_entry;
                end else begin
                    skid_valid_n = 1'b0;
                end
            end else if (accept) begin
                main_n = in_entry;
            end else begin
                main_valid_n = 1'b0;
            end
        end else if (accept) begin
            skid_n       = in_entry;
            skid_valid_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            main_q     <= main_n;
            skid_q     <= skid_n;
            main_valid <= main_valid_n;
            skid_valid <= skid_valid_n;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver pushes hand-computed ALU operands,
// a negedge monitor pops and compares on every fire.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_alu_op = '0;
    logic [4:0]  in_rs1_addr = '0, in_rs2_addr = '0, in_rd_addr = '0;
    logic [31:0] in_rs1_data = '0, in_rs2_data = '0, in_imm = '0;
    logic        in_use_imm = 1'b0, in_rd_wen = 1'b0, flush = 1'b0;
    logic        fwd_ex_wen = 1'b0, fwd_ex_is_load = 1'b0, fwd_wb_wen = 1'b0;
    logic [4:0]  fwd_ex_rd = '0, fwd_wb_rd = '0;
    logic [31:0] fwd_ex_data = '0, fwd_wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  alu_op;
    logic [31:0] alu_in0, alu_in1;
    logic [4:0]  out_rd_addr;
    logic        out_rd_wen;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] in0;
        logic [31:0] in1;
        logic [4:0]  rd;
        logic        wen;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_fail = 0;
    int   n_pop = 0;
    int   cyc = 0;
    logic [3:0] ops [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100,
                            4'b0110, 4'b1000, 4'b1010, 4'b1011};

    id_ex_stage #(.N_BITS(32), .N_REG_BITS(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_alu_op(in_alu_op),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_use_imm(in_use_imm),
        .in_rd_addr(in_rd_addr), .in_rd_wen(in_rd_wen), .flush(flush),
        .fwd_ex_wen(fwd_ex_wen), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
        .fwd_ex_is_load(fwd_ex_is_load),
        .fwd_wb_wen(fwd_wb_wen), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op),
        .alu_in0(alu_in0), .alu_in1(alu_in1),
        .out_rd_addr(out_rd_addr), .out_rd_wen(out_rd_wen)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every fire must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            exp_t e;
            exp_t a;
            a = '{op: alu_op, in0: alu_in0, in1: alu_in1, rd: out_rd_addr, wen: out_rd_wen};
            n_vec = n_vec + 1;
            if (exp_q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL unexpected_output: got op=%h in0=%h in1=%h rd=%0d wen=%b, none expected",
                         a.op, a.in0, a.in1, a.rd, a.wen);
            end else begin
                e = exp_q.pop_front();
                n_pop = n_pop + 1;
                if (a !== e) begin
                    n_fail = n_fail + 1;
                    $display("FAIL output_%0d: got op=%h in0=%h in1=%h rd=%0d wen=%b, want op=%h in0=%h in1=%h rd=%0d wen=%b",
                             n_pop, a.op, a.in0, a.in1, a.rd, a.wen, e.op, e.in0, e.in1, e.rd, e.wen);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Present one instruction and wait (bounded) for it to be accepted.
    task automatic send(input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                        input logic ui, input logic [4:0] rd, input logic wen,
                        input logic [31:0] e0, input logic [31:0] e1, input bit push);
        logic r;
        bit   done;
        done        = 1'b0;
        in_valid    = 1'b1;
        in_alu_op   = op;
        in_rs1_addr = rs1;
        in_rs2_addr = rs2;
        in_rs1_data = d1;
        in_rs2_data = d2;
        in_imm      = imm;
        in_use_imm  = ui;
        in_rd_addr  = rd;
        in_rd_wen   = wen;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            done = r;
        end
        if (!done) begin
            n_vec  = n_vec + 1;
            n_fail = n_fail + 1;
            $display("FAIL accept_timeout: got in_ready=0 for 100 cycles, want 1");
        end else if (push) begin
            exp_q.push_back('{op: op, in0: e0, in1: e1, rd: rd, wen: wen});
        end
    endtask

    task automatic stream_item(input int i, input logic [31:0] base);
        logic [31:0] d1, d2, imm;
        logic        ui;
        d1  = base + 32'(i);
        d2  = base + 32'h100 + 32'(i);
        imm = 32'hF000_0000 | 32'(i);
        ui  = (i % 2) == 1;
        send(ops[i], 5'(i + 1), 5'(i + 9), d1, d2, imm, ui, 5'(i + 16), ~ui,
             d1, ui ? imm : d2, 1'b1);
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            if (exp_q.size() == 0) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        n_vec = n_vec + 1;
        if (!ok) begin
            n_fail = n_fail + 1;
            $display("FAIL drain: got %0d outputs outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int c0;
        int p0;
        // reset state
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_in0", alu_in0, 32'd0);
        check("rst_in1", alu_in1, 32'd0);
        check("rst_rd", 32'({out_rd_addr, out_rd_wen}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // single ADD: latency one cycle, valid drops after fire
        send(4'b0000, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 1'b0, 5'd3, 1'b1, 32'd5, 32'd7, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        check("latency_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("after_fire_out_valid", 32'(out_valid), 32'd0);
        drain();

        // back-to-back stream, full throughput
        @(posedge clk);
        #1;
        c0 = cyc;
        p0 = n_pop;
        for (int i = 0; i < 8; i++) stream_item(i, 32'h100);
        in_valid = 1'b0;
        check("stream_cycles", 32'(cyc - c0), 32'd8);
        drain();
        check("stream_count", 32'(n_pop - p0), 32'd8);

        // stream with out_ready low for three edges
        p0 = n_pop;
        fork
            begin
                for (int i = 0; i < 8; i++) stream_item(i, 32'h500);
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check("stall_in_ready", 32'(in_ready), 32'd0);
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("stall_count", 32'(n_pop - p0), 32'd8);

        // forwarding priority and x0 exclusion
        fwd_ex_wen = 1'b1; fwd_ex_rd = 5'd3; fwd_ex_data = 32'hAA;
        fwd_wb_wen = 1'b1; fwd_wb_rd = 5'd3; fwd_wb_data = 32'hBB;
        send(4'b0000, 5'd3, 5'd5, 32'h11, 32'h22, 32'd0, 1'b0, 5'd7, 1'b1, 32'hAA, 32'h22, 1'b1);
        send(4'b1000, 5'd0, 5'd3, 32'h44, 32'h22, 32'd0, 1'b0, 5'd8, 1'b1, 32'h44, 32'hAA, 1'b1);
        send(4'b1100, 5'd3, 5'd3, 32'h11, 32'h22, 32'hFFFF_FFFC, 1'b1, 5'd9, 1'b1,
             32'hAA, 32'hFFFF_FFFC, 1'b1);
        in_valid = 1'b0;
        drain();
        fwd_ex_wen = 1'b0;
        send(4'b1110, 5'd3, 5'd6, 32'h11, 32'h66, 32'd0, 1'b0, 5'd10, 1'b1, 32'hBB, 32'h66, 1'b1);
        in_valid = 1'b0;
        drain();
        fwd_wb_wen = 1'b0;

        // load-use hazard on rs2, then released
        fwd_ex_wen = 1'b1; fwd_ex_rd = 5'd2; fwd_ex_data = 32'h33; fwd_ex_is_load = 1'b1;
        send(4'b0001, 5'd1, 5'd2, 32'h10, 32'h20, 32'd0, 1'b0, 5'd4, 1'b1, 32'h10, 32'h33, 1'b1);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hazard_stall", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1 fwd_ex_is_load = 1'b0;
        drain();
        fwd_ex_is_load = 1'b1;
        send(4'b0000, 5'd1, 5'd2, 32'h10, 32'h20, 32'd5, 1'b1, 5'd4, 1'b1, 32'h10, 32'd5, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        check("imm_no_stall", 32'(out_valid), 32'd1);
        drain();
        fwd_ex_wen = 1'b0; fwd_ex_is_load = 1'b0; fwd_ex_rd = '0;

        // flush with main and skid full and a pending input
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(4'b0001, 5'd1, 5'd2, 32'hDEAD, 32'hBEEF, 32'd0, 1'b0, 5'd11, 1'b1, 32'd0, 32'd0, 1'b0);
        send(4'b0010, 5'd1, 5'd2, 32'hCAFE, 32'hF00D, 32'd0, 1'b0, 5'd12, 1'b1, 32'd0, 32'd0, 1'b0);
        in_alu_op = 4'b1011; in_rd_addr = 5'd13; in_rs1_data = 32'h1234;
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(4'b0100, 5'd1, 5'd2, 32'h7, 32'h9, 32'd0, 1'b0, 5'd14, 1'b1, 32'h7, 32'h9, 1'b1);
        in_valid = 1'b0;
        drain();

        // asynchronous reset drops a held entry immediately
        out_ready = 1'b0;
        send(4'b0110, 5'd1, 5'd2, 32'h1, 32'h2, 32'd0, 1'b0, 5'd15, 1'b1, 32'd0, 32'd0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check("held_out_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
